// File: rtl/vector_cond_sequencer_pkg.sv
// Shared types and constants for the condition/vector-lane sequencer.
package vec_ctrl_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    // Lane index needs at least one bit even for a single-lane build.
    function automatic int lane_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vector_cond_sequencer_if.sv
// Decoder-side control bundle: decoded strobes in, gated enables and status out.
interface vector_cond_sequencer_if #(
    parameter int LANES = 4
);
    localparam int LANE_W = vec_ctrl_pkg::lane_width(LANES);

    logic              Valid;
    logic              VecOp;
    logic [3:0]        Cond;
    logic [3:0]        ALUFlags;
    logic [1:0]        FlagW;
    logic              RegW;
    logic              MemW;
    logic              PCS;
    logic              RegWrite;
    logic              MemWrite;
    logic              PCSrc;
    logic [LANE_W-1:0] Lane;
    logic              Stall;
    logic              Busy;
    logic [3:0]        Flags;

    modport master (
        output Valid, VecOp, Cond, ALUFlags, FlagW, RegW, MemW, PCS,
        input  RegWrite, MemWrite, PCSrc, Lane, Stall, Busy, Flags
    );

    modport slave (
        input  Valid, VecOp, Cond, ALUFlags, FlagW, RegW, MemW, PCS,
        output RegWrite, MemWrite, PCSrc, Lane, Stall, Busy, Flags
    );

endinterface

// File: rtl/vector_cond_sequencer_cond_check.sv
// Combinational ARM condition evaluation against the architectural NZCV flags.
module cond_check
    import vec_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[N_IDX];
    assign z = flags[Z_IDX];
    assign c = flags[C_IDX];
    assign v = flags[V_IDX];

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c && !z;
            COND_LS: cond_ex = !c || z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z && (n == v);
            COND_LE: cond_ex = z || (n != v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/vector_cond_sequencer.sv
// Condition-gates decoder write strobes, owns NZCV, and walks vector ops one lane per cycle.
module vector_cond_sequencer
    import vec_ctrl_pkg::*;
#(
    parameter int LANES = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    vector_cond_sequencer_if.slave bus
);

    localparam int LANE_W = lane_width(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_e            state_q, state_d;
    logic [LANE_W-1:0] cnt_q, cnt_d;
    logic [3:0]        flags_q, flags_d;
    logic              condex_lat, regw_lat, memw_lat;
    logic [1:0]        flagw_lat;
    logic              lat_load;
    logic              cond_ex;
    logic              last_lane;
    logic              regwrite, memwrite, pcsrc, stall, busy;

    function automatic logic [3:0] flag_update(
        input logic [3:0] cur,
        input logic [3:0] alu,
        input logic [1:0] fw,
        input logic       en
    );
        logic [3:0] nxt;
        nxt = cur;
        if (en && fw[1]) begin
            nxt[N_IDX] = alu[N_IDX];
            nxt[Z_IDX] = alu[Z_IDX];
        end
        if (en && fw[0]) begin
            nxt[C_IDX] = alu[C_IDX];
            nxt[V_IDX] = alu[V_IDX];
        end
        return nxt;
    endfunction

    cond_check u_cond_check (
        .cond    (bus.Cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign last_lane = (cnt_q == LAST_LANE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flags_d  = flags_q;
        lat_load = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        pcsrc    = 1'b0;
        stall    = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Valid) begin
                    regwrite = bus.RegW & cond_ex;
                    memwrite = bus.MemW & cond_ex;
                    if (!bus.VecOp) begin
                        pcsrc   = bus.PCS & cond_ex;
                        flags_d = flag_update(flags_q, bus.ALUFlags, bus.FlagW, cond_ex);
                    end else if (LANES > 1) begin
                        // Lane 0 issues now; later lanes replay the captured controls.
                        stall    = 1'b1;
                        lat_load = 1'b1;
                        state_d  = RUN;
                        cnt_d    = LANE_W'(1);
                    end else begin
                        flags_d = flag_update(flags_q, bus.ALUFlags, bus.FlagW, cond_ex);
                    end
                end
            end
            RUN: begin
                busy     = 1'b1;
                regwrite = regw_lat & condex_lat;
                memwrite = memw_lat & condex_lat;
                stall    = !last_lane;
                if (last_lane) begin
                    // Only the final lane's ALU flags are architecturally visible.
                    flags_d = flag_update(flags_q, bus.ALUFlags, flagw_lat, condex_lat);
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LANE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q    <= 4'b0000;
            condex_lat <= 1'b0;
            regw_lat   <= 1'b0;
            memw_lat   <= 1'b0;
            flagw_lat  <= 2'b00;
        end else begin
            flags_q <= flags_d;
            if (lat_load) begin
                condex_lat <= cond_ex;
                regw_lat   <= bus.RegW;
                memw_lat   <= bus.MemW;
                flagw_lat  <= bus.FlagW;
            end
        end
    end

    // Combinational strobes are forced low while reset is held.
    assign bus.RegWrite = rst_n & regwrite;
    assign bus.MemWrite = rst_n & memwrite;
    assign bus.PCSrc    = rst_n & pcsrc;
    assign bus.Stall    = rst_n & stall;
    assign bus.Busy     = rst_n & busy;
    assign bus.Lane     = cnt_q;
    assign bus.Flags    = flags_q;

endmodule

// File: tb/tb_vector_cond_sequencer.sv
// Scoreboarded bench for vector_cond_sequencer with LANES=4.
module tb_vector_cond_sequencer;

    localparam logic [3:0] EQ = 4'b0000, NE = 4'b0001, HI = 4'b1000, GE = 4'b1010;
    localparam logic [3:0] LT = 4'b1011, GT = 4'b1100, AL = 4'b1110;

    typedef struct packed {
        logic       v;
        logic       vec;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       rw;
        logic       mw;
        logic       pcs;
        logic [10:0] exp;
    } row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [10:0] exp_q[$];
    logic [10:0] got, want;

    always #5 clk = ~clk;

    vector_cond_sequencer_if #(.LANES(4)) bus ();

    vector_cond_sequencer #(.LANES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wire [10:0] obs = {bus.RegWrite, bus.MemWrite, bus.PCSrc, bus.Lane,
                       bus.Stall, bus.Busy, bus.Flags};

    function automatic logic [10:0] E(input logic rw, input logic mw, input logic pc,
                                      input logic [1:0] ln, input logic st,
                                      input logic bz, input logic [3:0] fl);
        return {rw, mw, pc, ln, st, bz, fl};
    endfunction

    function automatic row_t mk(input logic v, input logic vec, input logic [3:0] cond,
                                input logic [3:0] alu, input logic [1:0] fw, input logic rw,
                                input logic mw, input logic pcs, input logic [10:0] exp);
        row_t r;
        r = '{v, vec, cond, alu, fw, rw, mw, pcs, exp};
        return r;
    endfunction

    task automatic drive(input logic v, input logic vec, input logic [3:0] cond,
                         input logic [3:0] alu, input logic [1:0] fw, input logic rw,
                         input logic mw, input logic pcs);
        bus.Valid = v;
        bus.VecOp = vec;
        bus.Cond = cond;
        bus.ALUFlags = alu;
        bus.FlagW = fw;
        bus.RegW = rw;
        bus.MemW = mw;
        bus.PCS = pcs;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        next_cycle();
        drive(1, 1, AL, 4'b1111, 2'b11, 1, 1, 1);
        exp_q.push_back(E(0, 0, 0, 2'd0, 0, 0, 4'b0000));
        @(negedge clk);
        got = obs; want = exp_q.pop_front(); n_total++;
        if (got !== want) $display("FAIL reset_hold: got %b required %b", got, want);
        else n_pass++;
        next_cycle();
        rst_n = 1'b1;
        drive(0, 0, AL, 4'b0000, 2'b00, 0, 0, 0);
        exp_q.push_back(E(0, 0, 0, 2'd0, 0, 0, 4'b0000));
        @(negedge clk);
        got = obs; want = exp_q.pop_front(); n_total++;
        if (got !== want) $display("FAIL reset_release: got %b required %b", got, want);
        else n_pass++;
    endtask

    task automatic test_scalar();
        row_t tbl[13];
        tbl[0]  = mk(1, 0, AL, 4'b0100, 2'b11, 1, 0, 0, E(1, 0, 0, 0, 0, 0, 4'b0000));
        tbl[1]  = mk(1, 0, EQ, 4'b0000, 2'b00, 0, 0, 1, E(0, 0, 1, 0, 0, 0, 4'b0100));
        tbl[2]  = mk(1, 0, AL, 4'b0000, 2'b11, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 4'b0100));
        tbl[3]  = mk(1, 0, EQ, 4'b0000, 2'b00, 0, 0, 1, E(0, 0, 0, 0, 0, 0, 4'b0000));
        tbl[4]  = mk(1, 0, AL, 4'b1011, 2'b10, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 4'b0000));
        tbl[5]  = mk(1, 0, AL, 4'b0111, 2'b01, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 4'b1000));
        tbl[6]  = mk(1, 0, GE, 4'b0000, 2'b00, 0, 1, 0, E(0, 1, 0, 0, 0, 0, 4'b1011));
        tbl[7]  = mk(1, 0, GT, 4'b0000, 2'b00, 1, 0, 0, E(1, 0, 0, 0, 0, 0, 4'b1011));
        tbl[8]  = mk(1, 0, HI, 4'b0000, 2'b00, 0, 1, 1, E(0, 1, 1, 0, 0, 0, 4'b1011));
        tbl[9]  = mk(1, 0, LT, 4'b0000, 2'b00, 1, 0, 0, E(0, 0, 0, 0, 0, 0, 4'b1011));
        tbl[10] = mk(1, 0, LT, 4'b0000, 2'b11, 1, 0, 0, E(0, 0, 0, 0, 0, 0, 4'b1011));
        tbl[11] = mk(0, 0, AL, 4'b0000, 2'b11, 1, 1, 1, E(0, 0, 0, 0, 0, 0, 4'b1011));
        tbl[12] = mk(0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 4'b1011));
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            drive(tbl[i].v, tbl[i].vec, tbl[i].cond, tbl[i].alu, tbl[i].fw,
                  tbl[i].rw, tbl[i].mw, tbl[i].pcs);
            exp_q.push_back(tbl[i].exp);
            @(negedge clk);
            got = obs; want = exp_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL scalar[%0d]: got %b required %b", i, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_vector_walk();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (i < 4) begin
                drive(1, 1, AL, 4'b0000, 2'b00, 1, 0, 1);
                exp_q.push_back(E(1, 0, 0, 2'(i), i != 3, i != 0, 4'b1011));
            end else begin
                drive(0, 0, AL, 4'b0000, 2'b00, 0, 0, 0);
                exp_q.push_back(E(0, 0, 0, 2'd0, 0, 0, 4'b1011));
            end
            @(negedge clk);
            got = obs; want = exp_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL vec_walk[%0d]: got %b required %b", i, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_cond_false();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            if (i == 0) begin
                drive(1, 0, AL, 4'b0100, 2'b11, 0, 0, 0);
                exp_q.push_back(E(0, 0, 0, 2'd0, 0, 0, 4'b1011));
            end else if (i < 5) begin
                drive(1, 1, NE, 4'b1111, 2'b11, 1, 1, 0);
                exp_q.push_back(E(0, 0, 0, 2'(i - 1), i != 4, i != 1, 4'b0100));
            end else begin
                drive(0, 0, AL, 4'b0000, 2'b00, 0, 0, 0);
                exp_q.push_back(E(0, 0, 0, 2'd0, 0, 0, 4'b0100));
            end
            @(negedge clk);
            got = obs; want = exp_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL cond_false[%0d]: got %b required %b", i, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_vector_flags();
        logic [3:0] alu;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            alu = 4'b1000 >> i;
            if (i == 0) begin
                drive(1, 1, AL, alu, 2'b11, 1, 0, 0);
                exp_q.push_back(E(1, 0, 0, 2'd0, 1, 0, 4'b0100));
            end else if (i < 4) begin
                drive(0, 0, NE, alu, 2'b00, 0, 1, 1);
                exp_q.push_back(E(1, 0, 0, 2'(i), i != 3, 1, 4'b0100));
            end else begin
                drive(0, 0, AL, 4'b0000, 2'b00, 0, 0, 0);
                exp_q.push_back(E(0, 0, 0, 2'd0, 0, 0, 4'b0001));
            end
            @(negedge clk);
            got = obs; want = exp_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL vec_flags[%0d]: got %b required %b", i, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic rw, mw;
        // Ops A (RegW) and B (MemW) back to back, then three lanes of op C.
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            rw = (i < 4) || (i >= 8);
            mw = (i >= 4) && (i < 8);
            drive(1, 1, AL, 4'b0000, 2'b00, rw, mw, 0);
            exp_q.push_back(E(rw, mw, 0, 2'(i % 4), (i % 4) != 3, (i % 4) != 0, 4'b0001));
            @(negedge clk);
            got = obs; want = exp_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL b2b[%0d]: got %b required %b", i, got, want);
            else n_pass++;
        end
        rst_n = 1'b0;
        #1;
        exp_q.push_back(E(0, 0, 0, 2'd0, 0, 0, 4'b0000));
        got = obs; want = exp_q.pop_front(); n_total++;
        if (got !== want) $display("FAIL async_abort: got %b required %b", got, want);
        else n_pass++;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            if (i == 1) begin
                drive(1, 0, AL, 4'b0000, 2'b00, 1, 0, 0);
                exp_q.push_back(E(1, 0, 0, 2'd0, 0, 0, 4'b0000));
            end else begin
                drive(0, 0, AL, 4'b0000, 2'b00, 0, 0, 0);
                exp_q.push_back(E(0, 0, 0, 2'd0, 0, 0, 4'b0000));
            end
            @(negedge clk);
            got = obs; want = exp_q.pop_front(); n_total++;
            if (got !== want) $display("FAIL post_abort[%0d]: got %b required %b", i, got, want);
            else n_pass++;
        end
    endtask

    initial begin
        drive(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0);
        repeat (2) @(posedge clk);
        test_reset();
        test_scalar();
        test_vector_walk();
        test_cond_false();
        test_vector_flags();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vector_cond_sequencer.md
Name: vector_cond_sequencer

Overview:
Sits directly downstream of the instruction decoder. It consumes the decoder's control strobes (RegW, MemW, PCS, FlagW) and the instruction condition field, and holds the architectural NZCV flag register. It produces the final condition-gated write enables and the PC-select signal. For vector instructions it steps an element-lane counter across all lanes, one lane per cycle, and stalls fetch until the last lane issues.

Parameters:
LANES, 4, number of vector lanes; legal range 1..16.
LANE_W, $clog2(LANES) with minimum 1, localparam width of the lane index.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
Valid  input  1  decoded instruction present this cycle.
VecOp  input  1  instruction is a vector operation.
Cond  input  4  ARM condition field (EQ..AL, 1111 treated as AL).
ALUFlags  input  4  {N,Z,C,V} from the ALU for the lane or scalar op executing this cycle.
FlagW  input  2  [1] updates N,Z; [0] updates C,V.
RegW  input  1  decoder register-write request.
MemW  input  1  decoder memory-write request.
PCS  input  1  decoder PC-write request.
RegWrite  output  1  gated register-file write enable.
MemWrite  output  1  gated data-memory write enable.
PCSrc  output  1  select ALU result as next PC.
Lane  output  LANE_W  lane index being issued.
Stall  output  1  hold PC and IF/decode inputs.
Busy  output  1  FSM in RUN.
Flags  output  4  registered {N,Z,C,V}.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, lane counter=0, Flags=0000, latched controls=0. All outputs are 0 while in reset.
- CondEx is combinational from Cond and the registered Flags, using the standard 16 ARM conditions. Example: GE is N==V; GT is !Z && N==V; HI is C && !Z.
- Scalar op (state IDLE, Valid=1, VecOp=0):
  - RegWrite = RegW&CondEx; MemWrite = MemW&CondEx; PCSrc = PCS&CondEx.
  - Flags update at the next edge per FlagW gated by CondEx.
  - Lane=0, Stall=0. Single-cycle operation, no FSM change.
- Vector op start (state IDLE, Valid=1, VecOp=1):
  - Capture CondEx, RegW, MemW and FlagW into latches.
  - Lane 0 issues this cycle: RegWrite = RegW&CondEx, MemWrite = MemW&CondEx.
  - PCSrc=0 always for vector ops; PCS is ignored.
  - If LANES>1: Stall=1; go to RUN with counter=1 at the next edge.
  - If LANES==1: behaves as a scalar op with no stall.
- RUN:
  - Lane=counter. Enables come from the latched controls ANDed with the latched CondEx.
  - Valid, VecOp, Cond, RegW, MemW, PCS and FlagW are ignored. Flags are not re-evaluated.
  - Stall=1, Busy=1, except on the last lane (counter==LANES-1), where Stall=0.
  - Counter increments each cycle. After the last lane: return to IDLE, counter=0.
- Vector flag update: only on the last lane's cycle, from that cycle's ALUFlags, per latched FlagW, gated by latched CondEx. Earlier lanes never write Flags.
- Valid=0 in IDLE: all enables 0, Stall=0, Flags hold.
- Condition false on a vector op: the full lane walk still occurs, with Stall asserted for the same number of cycles (fixed timing), but every write enable and the flag update are suppressed.
- Back-to-back vector ops: the second is presented only after Stall drops. It is accepted in the IDLE cycle that follows the last lane, with no bubble.
- Reset asserted mid-RUN: immediate abort to IDLE. Partial lane writes already performed are not undone.

Decomposition:
- Shared package vec_ctrl_pkg holds:
  - cond_e enum of the 16 condition codes;
  - state_e {IDLE, RUN};
  - flag index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
- One sub-module, cond_check: purely combinational mapping Cond, Flags -> CondEx. The FSM, counter and flag register live in the top module.

Test Plan:
- Reset: hold rst_n=0 mid-sequence -> all outputs 0, Flags=0000; release -> IDLE, Lane=0.
- Scalar SUBS with Cond=AL, FlagW=11, ALUFlags=0100 -> Flags=0100 next cycle; following BEQ with PCS=1 -> PCSrc=1; with Flags=0000 -> PCSrc=0.
- Vector add with LANES=4, Cond=AL, RegW=1 -> Lane 0,1,2,3 on four consecutive cycles, RegWrite=1 each cycle, Stall=1,1,1,0, Busy=0,1,1,1.
- Vector op with Cond=NE while Z=1 -> four-cycle walk, RegWrite=MemWrite=0 throughout, Flags unchanged.
- Vector op with FlagW=11 and ALUFlags changing per lane (1000, 0100, 0010, 0001) -> Flags=0001 after the last lane only. Mid-walk Cond/RegW toggles are ignored.
- Back-to-back vector ops, plus rst_n pulsed at lane 2 of a third op -> second op starts the cycle after Stall falls; on reset the counter returns to 0 and state returns to IDLE asynchronously.
